oh_aoi_pipe: RTL and testbench
==============================

OH_AOI_PIPE -- requirements
Module: oh_aoi_pipe

Interface
REQ-001 Parameter DW, default 1, bit width of every term and of the result.
REQ-002 Parameter NT, default 3, number of AND-pair terms (NT>=1).
REQ-003 Parameter CW, default 8, width of the accepted-transaction counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 nreset  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  input transaction offered.
REQ-007 in_ready  output  1  block can accept a transaction this cycle.
REQ-008 a  input  NT*DW  first operand of each term; term i at bits [i*DW +: DW].
REQ-009 b  input  NT*DW  second operand of each term, same packing as a.
REQ-010 en  input  NT  per-transaction term enable; en[i]=0 removes term i.
REQ-011 inv  input  1  1 = AOI (inverted) result, 0 = AO (true) result.
REQ-012 out_valid  output  1  z holds a valid result.
REQ-013 out_ready  input  1  downstream accepts z this cycle.
REQ-014 z  output  DW  registered result.
REQ-015 count  output  CW  number of accepted input transactions, modulo 2^CW.

Function
REQ-016 Result SHALL be r = OR over i of (a_i & b_i & {DW{en[i]}}); z = inv ? ~r : r.
REQ-017 en = all zeros SHALL give r = 0, so z = all ones when inv=1 and all zeros when inv=0.
REQ-018 A transfer on either port SHALL occur only in a cycle where valid and ready are both 1.
REQ-019 An accepted input SHALL appear on z with out_valid=1 on the next cycle; latency is 1 cycle.
REQ-020 z and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 Results SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-022 Output register states: EMPTY, FULL. EMPTY->FULL on accept. FULL->EMPTY on drain with no accept. FULL stays FULL on simultaneous accept and drain, loading the new result.
REQ-023 count SHALL increment by 1 per accepted input and wrap from 2^CW-1 to 0.
REQ-024 in_valid, a, b, en and inv SHALL be ignored in cycles with no input transfer.

Reset
REQ-025 While nreset=0: out_valid=0, z=0, count=0, in_ready=0, and any skid entry is discarded.
REQ-026 in_ready SHALL be 1 in the first cycle after nreset returns to 1.
REQ-027 Asserting nreset mid-operation SHALL discard pending results with no output transfer.

Configuration
REQ-028 Macro OH_AOI_PIPE_SKID_EN SHALL select the ready scheme.
REQ-029 Without OH_AOI_PIPE_SKID_EN: in_ready = ~out_valid | out_ready (combinational path from out_ready), one result stored in total.
REQ-030 With OH_AOI_PIPE_SKID_EN: in_ready SHALL be a flop output, with a one-entry skid buffer for a second result.
REQ-031 With OH_AOI_PIPE_SKID_EN, an input accepted while FULL and out_ready=0 SHALL go to the skid, and in_ready SHALL be 0 next cycle.
REQ-032 With OH_AOI_PIPE_SKID_EN, the skid entry SHALL move to z on the next drain, and in_ready SHALL return to 1 the cycle after.
REQ-033 Both builds SHALL produce identical z sequences for identical accepted inputs.

Structure
REQ-034 Package oh_aoi_pkg SHALL hold the default DW, NT and CW values and the EMPTY/FULL state encoding.
REQ-035 Sub-module oh_aoi_reduce SHALL be the combinational NT-term masked AND-OR(-invert) reducer.
REQ-036 oh_aoi_reduce SHALL be instantiated once per stored result path (input to output register, input to skid).

Verification (NT=3, DW=4, CW=4)
REQ-037 Term2 a=F b=3, terms 1 and 0 zero, en=111, inv=1, out_ready=1 -> next cycle z=C, out_valid=1, count=1.
REQ-038 Same input with inv=0 and en=011 -> z=0; with en=000 and inv=1 -> z=F.
REQ-039 out_ready=0, three back-to-back offers -> no-skid build accepts 1, skid build accepts 2 and drops in_ready.
REQ-040 Continue REQ-039 with out_ready=1 -> results exit in acceptance order with no loss.
REQ-041 Skid build FULL with skid occupied, nreset=0 for 1 cycle -> out_valid=0, count=0, in_ready=0, then in_ready=1 next cycle, no stale z delivered.
REQ-042 16 accepted transactions -> count steps 1..F, then 0.
REQ-043 Random valid/ready stress in both builds -> z stream matches a reference model, with no stall deadlock.

Source files
------------

// File: rtl/oh_aoi_pkg.sv
// Shared defaults and state encoding for the masked AND-OR(-invert) pipe.
//   OH_AOI_DW_DEF : default width of each term and of the result
//   OH_AOI_NT_DEF : default number of AND-pair terms
//   OH_AOI_CW_DEF : default width of the accepted-transaction counter
//   oreg_state_e  : occupancy of the output register (EMPTY / FULL)
package oh_aoi_pkg;

  localparam int unsigned OH_AOI_DW_DEF = 1;
  localparam int unsigned OH_AOI_NT_DEF = 3;
  localparam int unsigned OH_AOI_CW_DEF = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } oreg_state_e;

endpackage : oh_aoi_pkg

// File: rtl/oh_aoi_reduce.sv
// Combinational NT-term masked AND-OR reducer with optional output inversion.
//   a, b : NT packed DW-bit operands, term i at [i*DW +: DW]
//   en   : per-term enable, a cleared bit removes that term from the OR
//   inv  : 1 = AOI (inverted) result, 0 = AO (true) result
//   z_c  : DW-bit combinational result
module oh_aoi_reduce
  import oh_aoi_pkg::*;
#(
  parameter int unsigned DW = OH_AOI_DW_DEF,
  parameter int unsigned NT = OH_AOI_NT_DEF
) (
  input  logic [NT*DW-1:0] a,
  input  logic [NT*DW-1:0] b,
  input  logic [NT-1:0]    en,
  input  logic             inv,
  output logic [DW-1:0]    z_c
);

  logic [DW-1:0] or_c;

  // OR together every enabled a_i & b_i; an all-zero enable leaves or_c at 0.
  always_comb begin
    or_c = '0;
    for (int unsigned i = 0; i < NT; i++) begin
      or_c = or_c | (a[i*DW +: DW] & b[i*DW +: DW] & {DW{en[i]}});
    end
    z_c = inv ? ~or_c : or_c;
  end

endmodule : oh_aoi_reduce

// File: rtl/oh_aoi_pipe.sv
// One-stage valid/ready pipe around the masked AND-OR(-invert) reducer.
// Build option: define OH_AOI_PIPE_SKID_EN to get a registered in_ready and
// a one-entry skid buffer; otherwise in_ready is derived combinationally from
// out_ready and only a single result is ever held.
//   clk, nreset          : clock, synchronous active-low reset
//   in_valid / in_ready  : input handshake (a, b, en, inv sampled on transfer)
//   a, b, en, inv        : operands, term enables, invert select
//   out_valid / out_ready: output handshake for z
//   z                    : registered result
//   count                : accepted input transactions, modulo 2^CW
module oh_aoi_pipe
  import oh_aoi_pkg::*;
#(
  parameter int unsigned DW = OH_AOI_DW_DEF,
  parameter int unsigned NT = OH_AOI_NT_DEF,
  parameter int unsigned CW = OH_AOI_CW_DEF
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NT*DW-1:0] a,
  input  logic [NT*DW-1:0] b,
  input  logic [NT-1:0]    en,
  input  logic             inv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    z,
  output logic [CW-1:0]    count
);

  oreg_state_e   state_q, state_d;
  logic [DW-1:0] z_q, z_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] res_out_c;
  logic          accept_c;
  logic          drain_c;

  // Result path feeding the output register.
  oh_aoi_reduce #(
    .DW (DW),
    .NT (NT)
  ) u_reduce_out (
    .a   (a),
    .b   (b),
    .en  (en),
    .inv (inv),
    .z_c (res_out_c)
  );

  assign out_valid = (state_q == ST_FULL);
  assign z         = z_q;
  assign count     = count_q;
  assign accept_c  = in_valid & in_ready;
  assign drain_c   = out_valid & out_ready;

  // Accepted-transaction counter, wraps naturally at 2^CW.
  always_comb begin
    count_d = count_q;
    if (accept_c) begin
      count_d = count_q + CW'(1);
    end
  end

`ifdef OH_AOI_PIPE_SKID_EN

  logic          skid_valid_q, skid_valid_d;
  logic [DW-1:0] skid_z_q, skid_z_d;
  logic          in_ready_q, in_ready_d;
  logic [DW-1:0] res_skid_c;

  // Result path feeding the skid entry.
  oh_aoi_reduce #(
    .DW (DW),
    .NT (NT)
  ) u_reduce_skid (
    .a   (a),
    .b   (b),
    .en  (en),
    .inv (inv),
    .z_c (res_skid_c)
  );

  // The ready flop comes out of reset set so the block accepts on the first
  // released cycle; reset itself forces in_ready low.
  assign in_ready = nreset & in_ready_q;

  // State, result, skid and counter registers.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q      <= ST_EMPTY;
      z_q          <= '0;
      count_q      <= '0;
      skid_valid_q <= 1'b0;
      skid_z_q     <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      z_q          <= z_d;
      count_q      <= count_d;
      skid_valid_q <= skid_valid_d;
      skid_z_q     <= skid_z_d;
      in_ready_q   <= in_ready_d;
    end
  end

  // Output-register occupancy plus skid fill/empty.
  always_comb begin
    state_d      = state_q;
    z_d          = z_q;
    skid_valid_d = skid_valid_q;
    skid_z_d     = skid_z_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept_c) begin
          state_d = ST_FULL;
          z_d     = res_out_c;
        end
      end
      ST_FULL: begin
        if (skid_valid_q) begin
          // in_ready is low here, so only a drain can happen.
          if (drain_c) begin
            z_d          = skid_z_q;
            skid_valid_d = 1'b0;
          end
        end else if (drain_c) begin
          if (accept_c) begin
            z_d = res_out_c;
          end else begin
            state_d = ST_EMPTY;
          end
        end else if (accept_c) begin
          // Stalled output: park the new result behind z.
          skid_valid_d = 1'b1;
          skid_z_d     = res_skid_c;
        end
      end
    endcase
    in_ready_d = ~skid_valid_d;
  end

`else

  // Room exists if the register is empty or is being drained this cycle.
  assign in_ready = nreset & (~out_valid | out_ready);

  // State, result and counter registers.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= ST_EMPTY;
      z_q     <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      count_q <= count_d;
    end
  end

  // Output-register occupancy; accept while draining reloads in place.
  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept_c) begin
          state_d = ST_FULL;
          z_d     = res_out_c;
        end
      end
      ST_FULL: begin
        if (accept_c) begin
          z_d = res_out_c;
        end else if (drain_c) begin
          state_d = ST_EMPTY;
        end
      end
    endcase
  end

`endif

endmodule : oh_aoi_pipe

// File: tb/tb_oh_aoi_pipe.sv
// Self-checking bench for oh_aoi_pipe (NT=3, DW=4, CW=4), either build.
module tb_oh_aoi_pipe;

  localparam int unsigned DW = 4;
  localparam int unsigned NT = 3;
  localparam int unsigned CW = 4;
`ifdef OH_AOI_PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic             clk;
  logic             nreset;
  logic             in_valid;
  logic             in_ready;
  logic [NT*DW-1:0] a;
  logic [NT*DW-1:0] b;
  logic [NT-1:0]    en;
  logic             inv;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    z;
  logic [CW-1:0]    count;

  oh_aoi_pipe #(
    .DW (DW),
    .NT (NT),
    .CW (CW)
  ) dut (
    .clk       (clk),
    .nreset    (nreset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .en        (en),
    .inv       (inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: FIFO of expected results plus an acceptance counter.
  logic [DW-1:0] mq[$];
  int            m_acc = 0;

  // Per-cycle samples (s_*) and model expectations (e_*).
  logic          s_rdy, s_ov, s_acc, s_drn;
  logic [DW-1:0] s_z;
  logic [CW-1:0] s_cnt;
  logic          e_rdy, e_ov;
  logic [DW-1:0] e_z;
  logic [CW-1:0] e_cnt;

  // Bit-by-bit evaluation of "OR of enabled a_i AND b_i", optionally inverted.
  function automatic logic [DW-1:0] ref_z(input logic [NT*DW-1:0] fa,
                                          input logic [NT*DW-1:0] fb,
                                          input logic [NT-1:0] fen,
                                          input logic finv);
    logic [DW-1:0] r;
    r = '0;
    for (int bi = 0; bi < int'(DW); bi++) begin
      for (int t = 0; t < int'(NT); t++) begin
        if (fen[t] && fa[t*DW+bi] && fb[t*DW+bi]) r[bi] = 1'b1;
      end
    end
    return finv ? ~r : r;
  endfunction

  // One clock: sample mid-cycle, form expectations, then advance the model.
  task automatic tick();
    @(negedge clk);
    s_rdy = in_ready;
    s_ov  = out_valid;
    s_z   = z;
    s_cnt = count;
    e_ov  = (mq.size() != 0);
    e_z   = e_ov ? mq[0] : '0;
    e_cnt = CW'(m_acc);
    if (SKID) e_rdy = nreset && (mq.size() < 2);
    else      e_rdy = nreset && ((mq.size() == 0) || out_ready);
    s_acc = nreset && in_valid && s_rdy;
    s_drn = nreset && s_ov && out_ready;
    @(posedge clk);
    if (!nreset) begin
      mq.delete();
      m_acc = 0;
    end else begin
      if (s_drn && mq.size() != 0) void'(mq.pop_front());
      if (s_acc) begin
        mq.push_back(ref_z(a, b, en, inv));
        m_acc++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    nreset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; en = '0; inv = 1'b0;
    tick();
    tick();
    n_chk++; if (s_ov !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b want 0", s_ov); end
    n_chk++; if (s_z !== 4'h0) begin n_err++; $display("FAIL reset_z: got %0h want 0", s_z); end
    n_chk++; if (s_cnt !== 4'h0) begin n_err++; $display("FAIL reset_count: got %0h want 0", s_cnt); end
    n_chk++; if (s_rdy !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %0b want 0", s_rdy); end
    nreset = 1'b1;
    tick();
    n_chk++; if (s_rdy !== 1'b1) begin n_err++; $display("FAIL release_in_ready: got %0b want 1", s_rdy); end
  endtask

  task automatic test_vectors();
    logic [DW-1:0] want [3];
    logic [NT-1:0] ens  [3];
    logic          invs [3];
    want[0] = 4'hC; ens[0] = 3'b111; invs[0] = 1'b1;
    want[1] = 4'h0; ens[1] = 3'b011; invs[1] = 1'b0;
    want[2] = 4'hF; ens[2] = 3'b000; invs[2] = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = 12'hF00; b = 12'h300; en = ens[k]; inv = invs[k]; in_valid = 1'b1;
      tick();
      n_chk++; if (s_rdy !== 1'b1) begin n_err++; $display("FAIL vec%0d_in_ready: got %0b want 1", k, s_rdy); end
      in_valid = 1'b0;
      tick();
      n_chk++; if (s_ov !== 1'b1) begin n_err++; $display("FAIL vec%0d_out_valid: got %0b want 1", k, s_ov); end
      n_chk++; if (s_z !== want[k]) begin n_err++; $display("FAIL vec%0d_z: got %0h want %0h", k, s_z, want[k]); end
      n_chk++; if (s_cnt !== CW'(k + 1)) begin n_err++; $display("FAIL vec%0d_count: got %0h want %0h", k, s_cnt, k + 1); end
    end
  endtask

  task automatic test_back_to_back();
    int n_acc = 0;
    int n_out = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a = 12'($urandom); b = 12'($urandom); en = 3'($urandom); inv = 1'($urandom);
      in_valid = 1'b1;
      tick();
      n_chk++; if (s_rdy !== e_rdy) begin n_err++; $display("FAIL b2b_in_ready%0d: got %0b want %0b", k, s_rdy, e_rdy); end
      if (s_acc) n_acc++;
    end
    in_valid = 1'b0;
    n_chk++; if (n_acc != (SKID ? 2 : 1)) begin n_err++; $display("FAIL b2b_accepts: got %0d want %0d", n_acc, SKID ? 2 : 1); end
    tick();
    n_chk++; if (s_rdy !== 1'b0) begin n_err++; $display("FAIL b2b_stalled_ready: got %0b want 0", s_rdy); end
    out_ready = 1'b1;
    for (int k = 0; k < 6 && mq.size() != 0; k++) begin
      tick();
      if (s_ov) begin
        n_out++;
        n_chk++; if (s_z !== e_z) begin n_err++; $display("FAIL b2b_drain_z%0d: got %0h want %0h", k, s_z, e_z); end
      end
    end
    n_chk++; if (n_out != n_acc) begin n_err++; $display("FAIL b2b_drained: got %0d want %0d", n_out, n_acc); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = 12'hFFF; b = 12'hFFF; en = 3'b111; inv = 1'b0;
    tick();
    a = 12'h00F; b = 12'h00F; en = 3'b001; inv = 1'b1;
    tick();
    in_valid = 1'b0;
    nreset = 1'b0;
    tick();
    n_chk++; if (s_rdy !== 1'b0) begin n_err++; $display("FAIL midrst_in_ready: got %0b want 0", s_rdy); end
    nreset = 1'b1;
    out_ready = 1'b1;
    tick();
    n_chk++; if (s_ov !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %0b want 0", s_ov); end
    n_chk++; if (s_cnt !== 4'h0) begin n_err++; $display("FAIL midrst_count: got %0h want 0", s_cnt); end
    n_chk++; if (s_rdy !== 1'b1) begin n_err++; $display("FAIL midrst_release_ready: got %0b want 1", s_rdy); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++; if (s_ov !== 1'b0) begin n_err++; $display("FAIL midrst_stale%0d: got %0b want 0", k, s_ov); end
    end
  endtask

  task automatic test_count_wrap();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      a = 12'($urandom); b = 12'($urandom); en = 3'($urandom); inv = 1'($urandom);
      tick();
      n_chk++; if (s_cnt !== CW'(k)) begin n_err++; $display("FAIL wrap_count%0d: got %0h want %0h", k, s_cnt, CW'(k)); end
      if (k > 0) begin
        n_chk++; if (s_z !== e_z) begin n_err++; $display("FAIL wrap_z%0d: got %0h want %0h", k, s_z, e_z); end
      end
    end
    in_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_random();
    int start_acc;
    start_acc = m_acc;
    for (int k = 0; k < 1500; k++) begin
      nreset    = ($urandom_range(0, 199) != 0);
      in_valid  = ($urandom_range(0, 9) < 6);
      out_ready = ($urandom_range(0, 9) < 6);
      a = 12'($urandom); b = 12'($urandom); en = 3'($urandom); inv = 1'($urandom);
      if (!nreset) start_acc = 0;
      tick();
      n_chk++; if (s_rdy !== e_rdy) begin n_err++; $display("FAIL rnd_in_ready@%0d: got %0b want %0b", k, s_rdy, e_rdy); end
      if (nreset) begin
        n_chk++; if (s_ov !== e_ov) begin n_err++; $display("FAIL rnd_out_valid@%0d: got %0b want %0b", k, s_ov, e_ov); end
        n_chk++; if (s_cnt !== e_cnt) begin n_err++; $display("FAIL rnd_count@%0d: got %0h want %0h", k, s_cnt, e_cnt); end
        if (e_ov) begin
          n_chk++; if (s_z !== e_z) begin n_err++; $display("FAIL rnd_z@%0d: got %0h want %0h", k, s_z, e_z); end
        end
      end
    end
    nreset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 10 && mq.size() != 0; k++) begin
      tick();
      if (e_ov) begin
        n_chk++; if (s_z !== e_z) begin n_err++; $display("FAIL rnd_final_z%0d: got %0h want %0h", k, s_z, e_z); end
      end
    end
    n_chk++; if (mq.size() != 0) begin n_err++; $display("FAIL rnd_deadlock: got %0d pending want 0", mq.size()); end
    n_chk++; if (m_acc - start_acc < 20) begin n_err++; $display("FAIL rnd_throughput: got %0d accepts want >=20", m_acc - start_acc); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_mid();
    test_count_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_oh_aoi_pipe
